// File: rtl/clock_pkg.sv
// Shared time-of-day constants and the hh:mm:ss -> seconds-of-day conversion.
// Latency: n/a (package, combinational helper only).
// Backpressure: n/a.
package clock_pkg;

  localparam int SEC_PER_DAY = 86400;
  localparam int HH_W        = 5;
  localparam int MM_W        = 6;
  localparam int SS_W        = 6;
  localparam int SEC_W       = 17;

  // hh*3600 + mm*60 + ss using shifts and adds only, so no multiplier is inferred.
  // 3600 = 2^11 + 2^10 + 2^9 + 2^4, 60 = 2^6 - 2^2. The alarm set path reuses this.
  function automatic logic [SEC_W-1:0] hms_to_sec(input logic [HH_W-1:0] hh,
                                                  input logic [MM_W-1:0] mm,
                                                  input logic [SS_W-1:0] ss);
    logic [SEC_W-1:0] h;
    logic [SEC_W-1:0] m;
    logic [SEC_W-1:0] s;
    h = SEC_W'(hh);
    m = SEC_W'(mm);
    s = SEC_W'(ss);
    return (h << 11) + (h << 10) + (h << 9) + (h << 4)
         + (m << 6) - (m << 2)
         + s;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ enabled cycles.
// Latency: tick is combinational, asserted in the terminal-count cycle itself.
// Backpressure: none; en=0 freezes the count in place, clr restarts the second.
module tick_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick only while enabled so a frozen clock never reports a second.
  assign tick = en && (cnt_q == TERM);

  // Next count: clear wins, otherwise count and roll at terminal, hold while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register; reset discards any partial second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sec_timekeeper.sv
// Time-of-day keeper: 1 Hz tick, hh/mm/ss and seconds-of-day, with set/adjust commands.
// Latency: a command or tick sampled at edge N is visible on every output after edge N.
// Backpressure: none; strobes are accepted every cycle, illegal sets are dropped with set_err.
// rst_n is expected to be deasserted synchronously to clk by the reset tree upstream.
module sec_timekeeper #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SEC_PER_DAY = 86400
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run_en,
  input  logic                        set_valid,
  input  logic [clock_pkg::HH_W-1:0]  set_hh,
  input  logic [clock_pkg::MM_W-1:0]  set_mm,
  input  logic [clock_pkg::SS_W-1:0]  set_ss,
  input  logic                        adj_min,
  input  logic                        adj_hour,
  output logic [clock_pkg::SEC_W-1:0] cur_sec,
  output logic [clock_pkg::HH_W-1:0]  hh,
  output logic [clock_pkg::MM_W-1:0]  mm,
  output logic [clock_pkg::SS_W-1:0]  ss,
  output logic                        sec_tick,
  output logic                        day_wrap,
  output logic                        set_err
);

  import clock_pkg::*;

  logic             tick;
  logic             set_legal;
  logic             min_carry;
  logic             hr_carry;
  logic [6:0]       mm_sum;
  logic [5:0]       hh_sum;

  logic [HH_W-1:0]  hh_q, hh_d;
  logic [MM_W-1:0]  mm_q, mm_d;
  logic [SS_W-1:0]  ss_q, ss_d;
  logic [SEC_W-1:0] cur_sec_q, cur_sec_d;
  logic             sec_tick_q, sec_tick_d;
  logic             day_wrap_q, day_wrap_d;
  logic             set_err_q, set_err_d;

  // A legal set restarts the second so the next tick is a full period after the load.
  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_en),
    .clr   (set_legal),
    .tick  (tick)
  );

  // Range check on the set fields.
  assign set_legal = set_valid && (set_hh <= HH_W'(23)) && (set_mm <= MM_W'(59))
                     && (set_ss <= SS_W'(59));

  // Carry chain of the tick alone; adjusts never carry upward.
  assign min_carry = tick && (ss_q == SS_W'(59));
  assign hr_carry  = min_carry && (mm_q == MM_W'(59));
  assign mm_sum    = 7'(mm_q) + 7'(adj_min) + 7'(min_carry);
  assign hh_sum    = 6'(hh_q) + 6'(adj_hour) + 6'(hr_carry);

  // Next-state mux: legal set > adjust (combined with any tick) > tick alone.
  always_comb begin
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    cur_sec_d  = cur_sec_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    set_err_d  = set_valid && !set_legal;
    if (set_legal) begin
      // Load wins outright; a coincident tick is swallowed along with its sec_tick.
      hh_d      = set_hh;
      mm_d      = set_mm;
      ss_d      = set_ss;
      cur_sec_d = hms_to_sec(set_hh, set_mm, set_ss);
    end else begin
      if (tick) begin
        ss_d = (ss_q == SS_W'(59)) ? '0 : ss_q + SS_W'(1);
      end
      // Sums stay below 2*modulus, so one conditional subtract is enough.
      mm_d = MM_W'((mm_sum >= 7'd60) ? mm_sum - 7'd60 : mm_sum);
      hh_d = HH_W'((hh_sum >= 6'd24) ? hh_sum - 6'd24 : hh_sum);
      if (adj_min || adj_hour) begin
        cur_sec_d = hms_to_sec(hh_d, mm_d, ss_d);
      end else if (tick) begin
        cur_sec_d = (cur_sec_q == SEC_W'(SEC_PER_DAY - 1)) ? '0 : cur_sec_q + SEC_W'(1);
      end
      sec_tick_d = tick;
      // Day rollover is the tick carrying out of hour 23; an hour adjust overrides it.
      day_wrap_d = hr_carry && (hh_q == HH_W'(23)) && !adj_hour;
    end
  end

  // Time and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      cur_sec_q  <= '0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      cur_sec_q  <= cur_sec_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
      set_err_q  <= set_err_d;
    end
  end

  assign hh       = hh_q;
  assign mm       = mm_q;
  assign ss       = ss_q;
  assign cur_sec  = cur_sec_q;
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;
  assign set_err  = set_err_q;

endmodule

// File: tb/tb_sec_timekeeper.sv
// Directed bench for sec_timekeeper with a 4-cycle second.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_sec_timekeeper;

  logic        clk;
  logic        rst_n;
  logic        run_en;
  logic        set_valid;
  logic [4:0]  set_hh;
  logic [5:0]  set_mm;
  logic [5:0]  set_ss;
  logic        adj_min;
  logic        adj_hour;
  logic [16:0] cur_sec;
  logic [4:0]  hh;
  logic [5:0]  mm;
  logic [5:0]  ss;
  logic        sec_tick;
  logic        day_wrap;
  logic        set_err;

  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt;

  sec_timekeeper #(
    .CLK_HZ      (4),
    .SEC_PER_DAY (86400)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_en    (run_en),
    .set_valid (set_valid),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .set_ss    (set_ss),
    .adj_min   (adj_min),
    .adj_hour  (adj_hour),
    .cur_sec   (cur_sec),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .sec_tick  (sec_tick),
    .day_wrap  (day_wrap),
    .set_err   (set_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ref_sec(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hh"}, 32'(hh), 32'(h));
    chk({tag, ".mm"}, 32'(mm), 32'(m));
    chk({tag, ".ss"}, 32'(ss), 32'(s));
    chk({tag, ".cur_sec"}, 32'(cur_sec), 32'(ref_sec(h, m, s)));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input int h, input int m, input int s);
    set_valid = 1'b1;
    set_hh    = 5'(h);
    set_mm    = 6'(m);
    set_ss    = 6'(s);
    cyc();
    set_valid = 1'b0;
  endtask

  // Invariant scoreboard: cur_sec must always match hh:mm:ss and stay within the day.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      assert ((int'(cur_sec) == ref_sec(int'(hh), int'(mm), int'(ss)))
              && (int'(cur_sec) < 86400)) else begin
        n_err++;
        $error("FAIL invariant observed=%0d expected=%0d", cur_sec,
               ref_sec(int'(hh), int'(mm), int'(ss)));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    run_en    = 1'b0;
    set_valid = 1'b0;
    set_hh    = '0;
    set_mm    = '0;
    set_ss    = '0;
    adj_min   = 1'b0;
    adj_hour  = 1'b0;
    cyc();
    cyc();

    // Reset state.
    chk_time("reset", 0, 0, 0);
    chk("reset.sec_tick", 32'(sec_tick), 32'd0);
    chk("reset.day_wrap", 32'(day_wrap), 32'd0);
    chk("reset.set_err", 32'(set_err), 32'd0);

    // 1: free run, tick on every 4th edge.
    rst_n  = 1'b1;
    run_en = 1'b1;
    tick_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      chk($sformatf("run.tick%0d", i), 32'(sec_tick), 32'((i % 4) == 0));
      if (sec_tick) tick_cnt++;
    end
    chk("run.tick_count", 32'(tick_cnt), 32'd10);
    chk_time("run.after40", 0, 0, 10);

    // 2: day wrap.
    do_set(23, 59, 58);
    chk_time("set235958", 23, 59, 58);
    chk("set235958.sec_tick", 32'(sec_tick), 32'd0);
    repeat (3) cyc();
    chk("wrap.pre1", 32'(sec_tick), 32'd0);
    cyc();
    chk_time("wrap.t1", 23, 59, 59);
    chk("wrap.t1.sec_tick", 32'(sec_tick), 32'd1);
    chk("wrap.t1.day_wrap", 32'(day_wrap), 32'd0);
    repeat (4) cyc();
    chk_time("wrap.t2", 0, 0, 0);
    chk("wrap.t2.sec_tick", 32'(sec_tick), 32'd1);
    chk("wrap.t2.day_wrap", 32'(day_wrap), 32'd1);
    cyc();
    chk("wrap.after.day_wrap", 32'(day_wrap), 32'd0);

    // 3: illegal sets are rejected, ticking continues (prescaler at 1 here).
    do_set(24, 0, 0);
    chk("bad_hh.set_err", 32'(set_err), 32'd1);
    chk_time("bad_hh", 0, 0, 0);
    do_set(5, 60, 0);
    chk("bad_mm.set_err", 32'(set_err), 32'd1);
    chk_time("bad_mm", 0, 0, 0);
    cyc();
    chk("bad.set_err_clr", 32'(set_err), 32'd0);
    chk("bad.tick", 32'(sec_tick), 32'd1);
    chk_time("bad.ticked", 0, 0, 1);

    // 4: legal set on the terminal-count cycle swallows the tick.
    repeat (3) cyc();
    chk("tc.pre", 32'(ss), 32'd1);
    do_set(12, 34, 56);
    chk_time("tc.load", 12, 34, 56);
    chk("tc.sec_tick", 32'(sec_tick), 32'd0);
    chk("tc.cur_sec_abs", 32'(cur_sec), 32'd45296);
    repeat (3) cyc();
    chk("tc.wait3", 32'(sec_tick), 32'd0);
    cyc();
    chk("tc.next_tick", 32'(sec_tick), 32'd1);
    chk_time("tc.next", 12, 34, 57);

    // 5: adj_min coincident with a carrying tick.
    do_set(10, 59, 59);
    chk("adj.pre_cur_sec", 32'(cur_sec), 32'd39599);
    repeat (3) cyc();
    adj_min = 1'b1;
    cyc();
    adj_min = 1'b0;
    chk_time("adj.min_tick", 11, 1, 0);
    chk("adj.min_tick.abs", 32'(cur_sec), 32'd39660);
    chk("adj.min_tick.sec_tick", 32'(sec_tick), 32'd1);
    do_set(23, 15, 20);
    adj_hour = 1'b1;
    cyc();
    adj_hour = 1'b0;
    chk_time("adj.hour_wrap", 0, 15, 20);
    chk("adj.hour_wrap.abs", 32'(cur_sec), 32'd920);
    adj_min  = 1'b1;
    adj_hour = 1'b1;
    cyc();
    adj_min  = 1'b0;
    adj_hour = 1'b0;
    chk_time("adj.both", 1, 16, 20);
    chk("adj.both.abs", 32'(cur_sec), 32'd4580);

    // 6: frozen clock, adjust while frozen, resume from held prescaler phase.
    run_en = 1'b0;
    tick_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (sec_tick) tick_cnt++;
    end
    chk("frozen.ticks", 32'(tick_cnt), 32'd0);
    chk_time("frozen", 1, 16, 20);
    adj_min = 1'b1;
    cyc();
    adj_min = 1'b0;
    chk_time("frozen.adj", 1, 17, 20);
    run_en = 1'b1;
    cyc();
    chk("resume.first", 32'(sec_tick), 32'd0);
    cyc();
    chk("resume.tick", 32'(sec_tick), 32'd1);
    chk_time("resume", 1, 17, 21);

    // Reset mid-second: outputs clear immediately, next tick a full period after release.
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    chk_time("arst", 0, 0, 0);
    chk("arst.sec_tick", 32'(sec_tick), 32'd0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("arst.no_early_tick", 32'(ss), 32'd0);
    cyc();
    chk("arst.tick", 32'(sec_tick), 32'd1);
    chk_time("arst.after", 0, 0, 1);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
